// File: rtl/serial_pattern_gen_if.sv
// Load handshake bundle for serial_pattern_gen.
// The producer offers a pattern word and bit count; the generator answers with load_ready.
interface serial_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;

  modport master (
    output load_valid,
    output load_data,
    output load_len,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_len,
    output load_ready
  );
endinterface

// File: rtl/serial_pattern_gen.sv
// MSB-first serializer of a loaded pattern onto x, one bit per clock.
// Define SERIAL_PATTERN_GEN_GAP_EN to add one idle GAP cycle after each pattern.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_pattern_gen_if.slave load,
  output logic                x,
  output logic                x_valid,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SERIAL_PATTERN_GEN_GAP_EN
    , GAP = 2'd2
`endif
  } state_t;

  localparam logic [LEN_W-1:0] FULL = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO  = LEN_W'(2);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [LEN_W-1:0] cnt;
  logic             last;
  logic             take;
  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] shamt;
  logic [WIDTH-1:0] aligned;

  // cnt counts bits still owed, including the one on x now
  assign last = (state == SHIFT) && (cnt == ONE);

`ifdef SERIAL_PATTERN_GEN_GAP_EN
  assign load.load_ready = !rst_n && (state == IDLE);
`else
  assign load.load_ready = !rst_n && ((state == IDLE) || last);
`endif

  assign take = load.load_valid && load.load_ready;

  always_comb begin
    eff_len = load.load_len;
    unique case (1'b1)
      (load.load_len == '0):  eff_len = FULL;
      (load.load_len > FULL): eff_len = FULL;
      default:                eff_len = load.load_len;
    endcase
    shamt   = FULL - eff_len;
    aligned = load.load_data << shamt;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (take) begin
      state   <= SHIFT;
      sreg    <= aligned << 1;
      cnt     <= eff_len;
      x       <= aligned[WIDTH-1];
      x_valid <= 1'b1;
      busy    <= 1'b1;
      done    <= (eff_len == ONE);
    end else begin
      unique case (state)
        IDLE: begin
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        SHIFT: begin
          if (cnt > ONE) begin
            sreg    <= sreg << 1;
            cnt     <= cnt - ONE;
            x       <= sreg[WIDTH-1];
            x_valid <= 1'b1;
            busy    <= 1'b1;
            done    <= (cnt == TWO);
          end else begin
            sreg    <= '0;
            cnt     <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_PATTERN_GEN_GAP_EN
            state   <= GAP;
            busy    <= 1'b1;
`else
            state   <= IDLE;
            busy    <= 1'b0;
`endif
          end
        end
`ifdef SERIAL_PATTERN_GEN_GAP_EN
        GAP: begin
          state   <= IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
`endif
        default: begin
          state   <= IDLE;
          sreg    <= '0;
          cnt     <= '0;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed scenarios plus random traffic
// against a queue-of-bits reference model.
module tb_serial_pattern_gen;
  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);
`ifdef SERIAL_PATTERN_GEN_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic x;
  logic x_valid;
  logic busy;
  logic done;

  serial_pattern_gen_if #(.WIDTH(WIDTH)) lif ();

  serial_pattern_gen #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lif),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // One entry per output cycle still owed: a pattern bit or a gap slot
  typedef struct packed {
    logic v;
    logic b;
    logic d;
    logic bz;
  } ent_t;

  ent_t q[$];
  ent_t cur = '0;
  logic acc;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic m_ready();
    if (rst_n) return 1'b0;
    if (q.size() != 0) return 1'b0;
    if (GAP_EN && cur.bz) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4:0] exp_vec();
    return {cur.b & cur.v, cur.v, cur.bz, cur.d, m_ready()};
  endfunction

  function automatic logic [4:0] obs();
    return {x, x_valid, busy, done, lif.load_ready};
  endfunction

  task automatic apply(input logic r, input logic v,
                       input logic [WIDTH-1:0] d,
                       input logic [LEN_W-1:0] l);
    @(negedge clk);
    rst_n          = r;
    lif.load_valid = v;
    lif.load_data  = d;
    lif.load_len   = l;
    #1;
  endtask

  task automatic advance();
    int L;
    acc = lif.load_valid && m_ready();
    @(posedge clk);
    if (rst_n) begin
      q.delete();
      cur = '0;
    end else begin
      if (acc) begin
        L = (lif.load_len == '0 || int'(lif.load_len) > WIDTH)
            ? WIDTH : int'(lif.load_len);
        for (int i = L - 1; i >= 0; i--)
          q.push_back(ent_t'{v: 1'b1, b: lif.load_data[i],
                             d: (i == 0), bz: 1'b1});
        if (GAP_EN)
          q.push_back(ent_t'{v: 1'b0, b: 1'b0, d: 1'b0, bz: 1'b1});
      end
      if (q.size() != 0) cur = q.pop_front();
      else cur = '0;
    end
  endtask

  task automatic test_reset();
    logic [4:0] want;
    apply(1'b1, 1'b1, WIDTH'($urandom), LEN_W'($urandom));
    advance();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) apply(1'b1, 1'b1, WIDTH'($urandom), LEN_W'(3));
      else apply(1'b0, 1'b0, '0, '0);
      want = (k == 0) ? 5'b00000 : 5'b00001;
      n_cmp++;
      if (obs() !== want) begin
        n_bad++;
        $display("FAIL reset k%0d: x,xv,busy,done,rdy got %b want %b",
                 k, obs(), want);
      end
      advance();
    end
  endtask

  task automatic test_single();
    logic [15:0] cap;
    int nv;
    int dk;
    cap = '0; nv = 0; dk = -1;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) apply(1'b0, 1'b1, 8'h0B, LEN_W'(4));
      else apply(1'b0, 1'b0, '0, '0);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_bad++;
        $display("FAIL single k%0d: got %b want %b", k, obs(), exp_vec());
      end
      if (x_valid === 1'b1) begin cap = {cap[14:0], x}; nv++; end
      if (done === 1'b1) dk = k;
      advance();
    end
    n_cmp++;
    if (cap[3:0] !== 4'b1011 || nv != 4 || dk != 4) begin
      n_bad++;
      $display("FAIL single_seq: bits %b n%0d done@%0d want 1011 n4 done@4",
               cap[3:0], nv, dk);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cap;
    logic sent2;
    int ak, fv, lv, nd, nv;
    cap = '0; sent2 = 1'b0; ak = -1; fv = -1; lv = -1; nd = 0; nv = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 0) apply(1'b0, 1'b1, 8'h0B, LEN_W'(4));
      else if (!sent2) apply(1'b0, 1'b1, 8'hA5, LEN_W'(8));
      else apply(1'b0, 1'b0, '0, '0);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_bad++;
        $display("FAIL b2b k%0d: got %b want %b", k, obs(), exp_vec());
      end
      if (x_valid === 1'b1) begin
        cap = {cap[14:0], x}; nv++;
        if (fv < 0) fv = k;
        lv = k;
      end
      if (done === 1'b1) nd++;
      advance();
      if (k > 0 && !sent2 && acc) begin sent2 = 1'b1; ak = k; end
    end
    n_cmp++;
    if (cap[11:0] !== 12'hBA5 || nv != 12 || nd != 2) begin
      n_bad++;
      $display("FAIL b2b_seq: bits %b n%0d dones %0d want 101110100101 n12 2",
               cap[11:0], nv, nd);
    end
    n_cmp++;
    if (ak != (GAP_EN ? 6 : 4) || (lv - fv + 1) != (GAP_EN ? 14 : 12)) begin
      n_bad++;
      $display("FAIL b2b_timing: accept@%0d span %0d want %0d %0d",
               ak, lv - fv + 1, GAP_EN ? 6 : 4, GAP_EN ? 14 : 12);
    end
  endtask

  task automatic test_len_clamp();
    logic [15:0] cap;
    logic [WIDTH-1:0] d;
    logic [LEN_W-1:0] l;
    int nv, dk;
    for (int t = 0; t < 2; t++) begin
      d = (t == 0) ? 8'h81 : WIDTH'($urandom);
      l = (t == 0) ? LEN_W'(0) : LEN_W'($urandom_range(WIDTH + 1, 15));
      cap = '0; nv = 0; dk = -1;
      for (int k = 0; k < 11; k++) begin
        if (k == 0) apply(1'b0, 1'b1, d, l);
        else apply(1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (obs() !== exp_vec()) begin
          n_bad++;
          $display("FAIL clamp%0d k%0d: got %b want %b", t, k, obs(), exp_vec());
        end
        if (x_valid === 1'b1) begin cap = {cap[14:0], x}; nv++; end
        if (done === 1'b1) dk = k;
        advance();
      end
      n_cmp++;
      if (cap[7:0] !== d || nv != 8 || dk != 8) begin
        n_bad++;
        $display("FAIL clamp%0d_seq len%0d: bits %b n%0d done@%0d want %b n8 done@8",
                 t, l, cap[7:0], nv, dk, d);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] cap;
    logic [WIDTH-1:0] d2;
    int nd, nv;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) apply(1'b0, 1'b1, WIDTH'($urandom), LEN_W'(8));
      else if (k == 3) apply(1'b1, 1'b1, WIDTH'($urandom), LEN_W'(2));
      else apply(1'b0, 1'b0, '0, '0);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rstmid k%0d: got %b want %b", k, obs(), exp_vec());
      end
      if (k == 4) begin
        n_cmp++;
        if (obs() !== 5'b00001) begin
          n_bad++;
          $display("FAIL rstmid_after: got %b want 00001", obs());
        end
      end
      if (done === 1'b1) nd++;
      advance();
    end
    n_cmp++;
    if (nd != 0) begin
      n_bad++;
      $display("FAIL rstmid_done: pulses %0d want 0", nd);
    end
    d2 = WIDTH'($urandom);
    cap = '0; nv = 0; nd = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) apply(1'b0, 1'b1, d2, LEN_W'(5));
      else apply(1'b0, 1'b0, '0, '0);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rstmid_fresh k%0d: got %b want %b", k, obs(), exp_vec());
      end
      if (x_valid === 1'b1) begin cap = {cap[14:0], x}; nv++; end
      if (done === 1'b1) nd++;
      advance();
    end
    n_cmp++;
    if (cap[4:0] !== d2[4:0] || nv != 5 || nd != 1) begin
      n_bad++;
      $display("FAIL rstmid_fresh_seq: bits %b n%0d dones %0d want %b n5 1",
               cap[4:0], nv, nd, d2[4:0]);
    end
  endtask

`ifdef SERIAL_PATTERN_GEN_GAP_EN
  task automatic test_gap();
    logic [15:0] cap;
    logic [5:0] xv;
    logic [1:0] rdy;
    int sent;
    cap = '0; xv = '0; rdy = '1; sent = 0;
    for (int k = 0; k < 10; k++) begin
      if (sent == 0) apply(1'b0, 1'b1, 8'h02, LEN_W'(2));
      else if (sent == 1) apply(1'b0, 1'b1, 8'h01, LEN_W'(2));
      else apply(1'b0, 1'b0, '0, '0);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_bad++;
        $display("FAIL gap k%0d: got %b want %b", k, obs(), exp_vec());
      end
      if (k >= 1 && k <= 6) xv = {xv[4:0], x_valid};
      if (k == 2) rdy[1] = lif.load_ready;
      if (k == 3) rdy[0] = lif.load_ready;
      if (x_valid === 1'b1) cap = {cap[14:0], x};
      advance();
      if (acc) sent++;
    end
    n_cmp++;
    if (xv !== 6'b110011 || rdy !== 2'b00 || cap[3:0] !== 4'b1001) begin
      n_bad++;
      $display("FAIL gap_seq: xv %b rdy %b bits %b want 110011 00 1001",
               xv, rdy, cap[3:0]);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(0, 39) == 0), 1'($urandom),
            WIDTH'($urandom), LEN_W'($urandom_range(0, 15)));
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random k%0d: got %b want %b", k, obs(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_len   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_len_clamp();
    test_reset_mid();
`ifdef SERIAL_PATTERN_GEN_GAP_EN
    test_gap();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Parallel-to-serial bit-stream transmitter feeding the single-bit `x` input of the sequence-detector FSMs. It accepts a pattern word plus a bit count over a valid/ready handshake, then drives the bits on `x`, one bit per clock and MSB-first. It qualifies each bit with `x_valid` and pulses `done` on the last bit. It lets the team drive detectors from RTL instead of hand-written stimulus.

## Interface
- `WIDTH`, 8: maximum pattern length in bits (≥2).
- `LEN_W`, $clog2(WIDTH+1): width of the length field.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: synchronous reset, active-high. Despite the suffix, reset is asserted when high and sampled only on the rising edge of `clk`.
- `load_valid` input 1: pattern offered.
- `load_ready` output 1: block can accept a pattern this cycle.
- `load_data` input WIDTH: pattern bits; bit `load_len-1` is sent first.
- `load_len` input LEN_W: number of bits to send.
- `x` output 1: serial bit to the detector; 0 whenever `x_valid`=0.
- `x_valid` output 1: `x` carries a pattern bit this cycle.
- `busy` output 1: high in any non-IDLE state.
- `done` output 1: one-cycle pulse concurrent with the last bit of a pattern.

## Operation
- Two states, IDLE and SHIFT; with the macro defined there is a third state, GAP.
- **Handshake:** a load is accepted on a rising edge where `load_valid && load_ready` both hold.
  - `load_ready` is high in IDLE.
  - `load_ready` is also high in SHIFT during the final-bit cycle, which allows back-to-back patterns without the macro.
  - `load_valid` in any other cycle is ignored; `load_data` and `load_len` are not sampled.
- **Length clamp:** effective length L = `load_len` if 1 ≤ `load_len` ≤ WIDTH, otherwise WIDTH. This covers 0 and any out-of-range value.
- **On accept:**
  - Shift register ← `load_data` aligned so that bit L-1 is presented first.
  - Bit counter ← L.
  - State → SHIFT.
- **SHIFT:** each cycle drives the current bit with `x_valid`=1, then shifts by one and decrements the counter.
  - When counter = 1, the current cycle is the last bit and `done`=1.
  - If a new load is accepted on that edge, stay in SHIFT with the new pattern.
  - Otherwise go to IDLE (or GAP with the macro).
- **IDLE:** `x`=0, `x_valid`=0, `busy`=0.
- **Reset values** (applied on the edge where `rst_n`=1):
  - State = IDLE.
  - `x`=0, `x_valid`=0, `busy`=0, `done`=0, `load_ready`=1 once reset deasserts.
  - `load_ready`=0 while `rst_n`=1.
  - Internal shift register and counter cleared.
- **Reset mid-pattern:** the remaining bits are discarded and `done` is not pulsed. A load offered in the reset cycle is not accepted.

## Timing
- `x`, `x_valid`, `busy` and `done` are registered outputs. `load_ready` is combinational from state and counter.
- Latency: a pattern accepted on edge N puts its first bit on `x` after edge N (cycle N+1). The last bit appears in cycle N+L, and `done` pulses in cycle N+L.
- Back-to-back loads (macro off): the first bit of the next pattern is in cycle N+L+1, so `x_valid` shows no bubble.
- Throughput: one bit per clock.

## Configuration
- Macro: `SERIAL_PATTERN_GEN_GAP_EN`.
- **Defined:** after every last bit the FSM enters GAP for exactly one cycle.
  - In GAP: `x`=0, `x_valid`=0, `busy`=1, `load_ready`=0.
  - Then → IDLE.
  - `load_ready` is not raised during the final-bit cycle.
  - The next pattern's first bit appears no earlier than cycle N+L+3.
- **Undefined:** there is no GAP state and back-to-back loads are allowed as described above.

## Test plan
- WIDTH=8; reset for 2 cycles, then idle 3 cycles -> `x`=0, `x_valid`=0, `busy`=0, `done`=0, `load_ready`=1 throughout.
- Load `load_data`=8'b0000_1011, `load_len`=4 -> `x` = 1,0,1,1 in cycles N+1..N+4; `x_valid`=1 for those 4 cycles; `done`=1 only in N+4; IDLE in N+5.
- Back-to-back (macro off): 4'b1011/len 4, then 8'hA5/len 8 held valid -> second load accepted in the final-bit cycle; `x` = 1,0,1,1,1,0,1,0,0,1,0,1 with no `x_valid` gap; two `done` pulses.
- `load_len`=0 with 8'h81 -> 8 bits sent, 1,0,0,0,0,0,0,1; `done` in N+8.
- Assert `rst_n` in the 3rd bit of an 8-bit pattern -> next cycle `x_valid`=0, `busy`=0, no `done`; a fresh load afterwards transmits correctly.
- With `SERIAL_PATTERN_GEN_GAP_EN` defined: two 2-bit loads 2'b10, 2'b01 offered continuously -> `x_valid` = 1,1,0(GAP),0(IDLE accept),1,1; `load_ready`=0 during the last bit and during GAP.
